// File: rtl/eq_sched_pkg.sv
// rtl/eq_sched_pkg.sv - shared types and constants for the EQ band scheduler
//
// Holds the scheduler state encoding, the channel encoding, default widths
// and the saturation limits used when folding band results into one sample.

package eq_sched_pkg;

  localparam int NUM_BANDS_DEF = 10;
  localparam int DATA_W_DEF    = 16;
  localparam int ACC_W_DEF     = 20;
  localparam int TIMEOUT_DEF   = 1023;

  // Clamp limits for a DATA_W_DEF-bit signed sample.
  localparam logic [DATA_W_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_PRESENT = 3'd4
  } sched_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/eq_sat_accum.sv
// rtl/eq_sat_accum.sv - signed clear/add accumulator with saturating output
//
// Ports:
//   Clk, Reset_   clock, asynchronous active-low reset
//   clear         zero the accumulator (wins over add_en)
//   add_en        add the sign-extended addend this cycle
//   addend        signed DATA_W operand
//   sat_next      accumulator value after this cycle's add, clamped to DATA_W

module eq_sat_accum
  import eq_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] addend,
  output logic [DATA_W-1:0] sat_next
);

  localparam logic [DATA_W-1:0] MAX_D =
    (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MAX) : {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_D =
    (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MIN) : {1'b1, {(DATA_W-1){1'b0}}};

  // Limits widened to the accumulator width for the signed compares.
  localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-DATA_W){MAX_D[DATA_W-1]}}, MAX_D};
  localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-DATA_W){MIN_D[DATA_W-1]}}, MIN_D};

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] addend_ext;
  logic signed [ACC_W-1:0] acc_next;

  assign addend_ext = add_en ? {{(ACC_W-DATA_W){addend[DATA_W-1]}}, addend} : '0;
  assign acc_next   = acc_q + addend_ext;

  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= acc_next;
    end
  end

  // The wide accumulator never wraps for NUM_BANDS full-scale terms, so the
  // clamp only has to compare against the DATA_W limits.
  always_comb begin
    sat_next = acc_next[DATA_W-1:0];
    if (acc_next > MAX_A) begin
      sat_next = MAX_D;
    end else if (acc_next < MIN_A) begin
      sat_next = MIN_D;
    end
  end

endmodule

// File: rtl/eq_band_scheduler.sv
// rtl/eq_band_scheduler.sv - per-frame sequencer for the equalizer FIR band bank
//
// Ports:
//   Clk, Reset_            clock, asynchronous active-low reset
//   SampleReq              frame tick; accepted only in IDLE
//   LeftIn, RightIn        stereo sample pair, latched on accept
//   BandMask               enabled bands, latched on accept
//   XOut                   current channel's sample driven to every band
//   BandStart              one-cycle start pulse to the enabled bands
//   BandReady, BandResult  per-band ready bits and flattened signed results
//   OutValid/OutReady      result handshake; OutData saturated sum,
//                          OutChannel 0=left 1=right
//   Busy                   state is not IDLE
//   TimeoutErr, OverrunErr sticky error flags, cleared by ClrErr

module eq_band_scheduler
  import eq_sched_pkg::*;
#(
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset_,
  input  logic                        SampleReq,
  input  logic [DATA_W-1:0]           LeftIn,
  input  logic [DATA_W-1:0]           RightIn,
  input  logic [NUM_BANDS-1:0]        BandMask,
  output logic [DATA_W-1:0]           XOut,
  output logic [NUM_BANDS-1:0]        BandStart,
  input  logic [NUM_BANDS-1:0]        BandReady,
  input  logic [NUM_BANDS*DATA_W-1:0] BandResult,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [DATA_W-1:0]           OutData,
  output logic                        OutChannel,
  output logic                        Busy,
  output logic                        TimeoutErr,
  output logic                        OverrunErr,
  input  logic                        ClrErr
);

  localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  sched_state_e state, next_state;
  chan_e        channel;

  logic [DATA_W-1:0]    left_q;
  logic [DATA_W-1:0]    right_q;
  logic [NUM_BANDS-1:0] mask_q;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     band_idx;
  logic [DATA_W-1:0]    out_data;
  logic                 timeout_err;
  logic                 overrun_err;

  // Control strobes from the next-state logic.
  logic accept;
  logic tmr_clr;
  logic tmr_inc;
  logic acc_clr;
  logic acc_add;
  logic load_sum;
  logic load_zero;
  logic set_timeout;
  logic to_right;

  logic              all_ready;
  logic [DATA_W-1:0] band_sel;
  logic [DATA_W-1:0] sat_next;

  assign all_ready = ((BandReady & mask_q) == mask_q);

  // Result of the band being accumulated this cycle; disabled bands add 0.
  always_comb begin
    band_sel = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (band_idx == IDX_W'(i)) begin
        band_sel = mask_q[i] ? BandResult[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  eq_sat_accum #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_accum (
    .Clk      (Clk),
    .Reset_   (Reset_),
    .clear    (acc_clr),
    .add_en   (acc_add),
    .addend   (band_sel),
    .sat_next (sat_next)
  );

  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    acc_clr     = 1'b0;
    acc_add     = 1'b0;
    load_sum    = 1'b0;
    load_zero   = 1'b0;
    set_timeout = 1'b0;
    to_right    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SampleReq) begin
          accept     = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_clr    = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_inc = 1'b1;
        // timer==0 is the guard cycle: bands may still show ready from the
        // previous channel, so their ready bits are not trusted yet.
        if (timer != '0 && all_ready) begin
          acc_clr    = 1'b1;
          next_state = ST_ACCUM;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          set_timeout = 1'b1;
          load_zero   = 1'b1;
          next_state  = ST_PRESENT;
        end
      end
      ST_ACCUM: begin
        acc_add = 1'b1;
        if (band_idx == IDX_W'(NUM_BANDS - 1)) begin
          load_sum   = 1'b1;
          next_state = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (OutReady) begin
          if (channel == CH_LEFT) begin
            to_right   = 1'b1;
            next_state = ST_ISSUE;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      channel  <= CH_LEFT;
      left_q   <= '0;
      right_q  <= '0;
      mask_q   <= '0;
      timer    <= '0;
      band_idx <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        left_q  <= LeftIn;
        right_q <= RightIn;
        mask_q  <= BandMask;
        channel <= CH_LEFT;
      end else if (to_right) begin
        channel <= CH_RIGHT;
      end

      if (tmr_clr) begin
        timer <= '0;
      end else if (tmr_inc) begin
        timer <= timer + 1'b1;
      end

      if (acc_clr) begin
        band_idx <= '0;
      end else if (acc_add) begin
        band_idx <= band_idx + 1'b1;
      end

      if (load_sum) begin
        out_data <= sat_next;
      end else if (load_zero) begin
        out_data <= '0;
      end
    end
  end

  // Sticky errors: a new error in the same cycle as ClrErr keeps the flag set.
  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end else if (ClrErr) begin
        timeout_err <= 1'b0;
      end

      if (SampleReq && state != ST_IDLE) begin
        overrun_err <= 1'b1;
      end else if (ClrErr) begin
        overrun_err <= 1'b0;
      end
    end
  end

  // Decoded straight from state so BandStart and OutValid fall with reset.
  assign BandStart  = (state == ST_ISSUE) ? mask_q : '0;
  assign OutValid   = (state == ST_PRESENT);
  assign Busy       = (state != ST_IDLE);
  assign XOut       = (channel == CH_RIGHT) ? right_q : left_q;
  assign OutData    = out_data;
  assign OutChannel = channel;
  assign TimeoutErr = timeout_err;
  assign OverrunErr = overrun_err;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// tb/tb_eq_band_scheduler.sv - self-checking bench for eq_band_scheduler

module tb_eq_band_scheduler;

  localparam int NB = 10;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int TO = 8;

  logic              Clk = 1'b0;
  logic              Reset_ = 1'b0;
  logic              SampleReq = 1'b0;
  logic [DW-1:0]     LeftIn = '0;
  logic [DW-1:0]     RightIn = '0;
  logic [NB-1:0]     BandMask = '0;
  logic [DW-1:0]     XOut;
  logic [NB-1:0]     BandStart;
  logic [NB-1:0]     BandReady = '0;
  logic [NB*DW-1:0]  BandResult = '0;
  logic              OutValid;
  logic              OutReady = 1'b0;
  logic [DW-1:0]     OutData;
  logic              OutChannel;
  logic              Busy;
  logic              TimeoutErr;
  logic              OverrunErr;
  logic              ClrErr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] res [NB];

  eq_band_scheduler #(
    .NUM_BANDS (NB),
    .DATA_W    (DW),
    .ACC_W     (AW),
    .TIMEOUT   (TO)
  ) dut (
    .Clk        (Clk),
    .Reset_     (Reset_),
    .SampleReq  (SampleReq),
    .LeftIn     (LeftIn),
    .RightIn    (RightIn),
    .BandMask   (BandMask),
    .XOut       (XOut),
    .BandStart  (BandStart),
    .BandReady  (BandReady),
    .BandResult (BandResult),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData),
    .OutChannel (OutChannel),
    .Busy       (Busy),
    .TimeoutErr (TimeoutErr),
    .OverrunErr (OverrunErr),
    .ClrErr     (ClrErr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a timed-out channel reports 0, otherwise the clamped sum of
  // the enabled bands' signed results.
  function automatic logic [DW-1:0] model_out(input logic [NB-1:0] m, input logic [NB-1:0] rdy);
    int sum;
    if ((rdy & m) != m) return '0;
    sum = 0;
    for (int i = 0; i < NB; i++) begin
      if (m[i]) sum += int'($signed(res[i]));
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return DW'(sum);
  endfunction

  task automatic apply_results();
    for (int i = 0; i < NB; i++) BandResult[i*DW +: DW] = res[i];
  endtask

  task automatic fill_results(input logic [DW-1:0] v);
    for (int i = 0; i < NB; i++) res[i] = v;
  endtask

  task automatic random_results();
    for (int i = 0; i < NB; i++) res[i] = DW'($urandom);
  endtask

  task automatic do_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic [NB-1:0] m, input logic [NB-1:0] rdy,
                          input int hold, input int ovr_step);
    logic [DW-1:0] exp_d;
    int exp_lat;
    int n;
    exp_d   = model_out(m, rdy);
    exp_lat = ((rdy & m) != m) ? TO + 2 : NB + 3;
    apply_results();
    BandReady = rdy;
    LeftIn    = l;
    RightIn   = r;
    BandMask  = m;
    SampleReq = 1'b1;
    step();
    SampleReq = 1'b0;
    // Live inputs change after the accept; only the latched copies matter.
    LeftIn    = DW'($urandom);
    RightIn   = DW'($urandom);
    BandMask  = NB'($urandom);
    for (int ch = 0; ch < 2; ch++) begin
      check("issue_bandstart", 32'(BandStart), 32'(m));
      check("issue_xout", 32'(XOut), (ch == 0) ? 32'(l) : 32'(r));
      n = 0;
      while (!OutValid && n < 200) begin
        SampleReq = (ch == 0 && n == ovr_step);
        step();
        n++;
        SampleReq = 1'b0;
        if (n == 1) check("wait_bandstart_low", 32'(BandStart), 32'd0);
      end
      check("present_latency", 32'(n), 32'(exp_lat));
      check("out_data", 32'(OutData), 32'(exp_d));
      check("out_channel", 32'(OutChannel), 32'(ch));
      for (int h = 0; h < hold; h++) begin
        step();
        check("hold_valid", 32'(OutValid), 32'd1);
        check("hold_data", 32'(OutData), 32'(exp_d));
        check("hold_channel", 32'(OutChannel), 32'(ch));
      end
      OutReady = 1'b1;
      step();
      OutReady = 1'b0;
      check("valid_drop", 32'(OutValid), 32'd0);
    end
    check("idle_after_frame", 32'(Busy), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(OutValid), 32'd0);
    check("rst_bandstart", 32'(BandStart), 32'd0);
    check("rst_outdata", 32'(OutData), 32'd0);
    check("rst_xout", 32'(XOut), 32'd0);
    check("rst_channel", 32'(OutChannel), 32'd0);
    check("rst_timeout", 32'(TimeoutErr), 32'd0);
    check("rst_overrun", 32'(OverrunErr), 32'd0);
    Reset_ = 1'b1;
    step();

    // Plain sum, both channels
    fill_results(16'h0100);
    do_frame(16'h1234, 16'hABCD, 10'h3FF, 10'h3FF, 0, -1);

    // Positive and negative saturation
    fill_results(16'h7000);
    do_frame(16'h0001, 16'h0002, 10'h3FF, 10'h3FF, 0, -1);
    fill_results(16'h9000);
    do_frame(16'h0003, 16'h0004, 10'h3FF, 10'h3FF, 0, -1);

    // Sparse mask ignores disabled bands
    fill_results(16'h1234);
    res[0] = 16'h0010;
    res[2] = 16'h0020;
    do_frame(16'h5555, 16'hAAAA, 10'h005, 10'h3FF, 0, -1);

    // All-zero mask passes on the second WAIT cycle with a zero sum
    random_results();
    do_frame(16'h0F0F, 16'hF0F0, 10'h000, 10'h000, 0, -1);

    // Band 3 never ready: both channels time out
    random_results();
    do_frame(16'h1111, 16'h2222, 10'h3FF, 10'h3F7, 0, -1);
    check("timeout_set", 32'(TimeoutErr), 32'd1);
    check("overrun_clear_before", 32'(OverrunErr), 32'd0);
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
    check("timeout_cleared", 32'(TimeoutErr), 32'd0);

    // Overrun during ACCUM, output held back for 5 cycles
    random_results();
    do_frame(16'h3333, 16'h4444, 10'h2D6, 10'h3FF, 5, 5);
    check("overrun_set", 32'(OverrunErr), 32'd1);
    check("timeout_still_clear", 32'(TimeoutErr), 32'd0);
    ClrErr = 1'b1;
    step();
    ClrErr = 1'b0;
    check("overrun_cleared", 32'(OverrunErr), 32'd0);

    // Reset during WAIT aborts the frame
    fill_results(16'h0100);
    apply_results();
    BandReady = '0;
    BandMask  = 10'h3FF;
    SampleReq = 1'b1;
    step();
    SampleReq = 1'b0;
    step();
    step();
    check("pre_reset_busy", 32'(Busy), 32'd1);
    Reset_ = 1'b0;
    #1;
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_valid", 32'(OutValid), 32'd0);
    check("async_rst_bandstart", 32'(BandStart), 32'd0);
    check("async_rst_outdata", 32'(OutData), 32'd0);
    check("async_rst_xout", 32'(XOut), 32'd0);
    step();
    Reset_ = 1'b1;
    step();
    check("post_rst_idle", 32'(Busy), 32'd0);
    do_frame(16'h7777, 16'h8888, 10'h3FF, 10'h3FF, 0, -1);

    // Randomized frames against the reference
    for (int f = 0; f < 8; f++) begin
      logic [NB-1:0] m;
      logic [NB-1:0] rdy;
      random_results();
      m   = NB'($urandom);
      rdy = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1;
      do_frame(DW'($urandom), DW'($urandom), m, rdy, $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eq_band_scheduler.md
Name: eq_band_scheduler

Overview:
- Sequences the equalizer FIR band bank once per stereo frame.
- Latches a left/right sample pair and drives each channel in turn onto the shared band-input bus, then pulses start to every enabled band.
- Waits for the enabled bands' ready bits, then accumulates their outputs serially with saturation.
- Presents one result per channel on a valid/ready output port. Replaces the free-running per-band summation with a controlled, timeout-protected schedule.

Parameters:
- NUM_BANDS, 10, number of FIR bands sequenced.
- DATA_W, 16, sample and band-result width (signed).
- ACC_W, 20, accumulator width; must be at least DATA_W+clog2(NUM_BANDS).
- TIMEOUT, 1023, maximum WAIT cycles before abandoning a channel.

Ports:
- Clk  in  1  system clock.
- Reset_  in  1  reset. One clock; reset is asynchronous and active-low.
- SampleReq  in  1  frame tick; starts a stereo frame.
- LeftIn  in  DATA_W  left sample; latched on accepted SampleReq.
- RightIn  in  DATA_W  right sample; latched on accepted SampleReq.
- BandMask  in  NUM_BANDS  enabled bands; latched on accepted SampleReq.
- XOut  out  DATA_W  sample driven to all bands.
- BandStart  out  NUM_BANDS  one-cycle start pulse per band.
- BandReady  in  NUM_BANDS  per-band result-ready bits.
- BandResult  in  NUM_BANDS*DATA_W  flattened signed results; band i at [i*DATA_W +: DATA_W].
- OutValid  out  1  result available.
- OutReady  in  1  consumer accepts.
- OutData  out  DATA_W  saturated sum.
- OutChannel  out  1  0=left, 1=right.
- Busy  out  1  high whenever the state is not IDLE.
- TimeoutErr  out  1  sticky.
- OverrunErr  out  1  sticky.
- ClrErr  in  1  clears both sticky errors.

Behaviour:
- Reset: state IDLE, channel 0. All outputs, latches, timer and accumulator are 0.
- States: IDLE, ISSUE, WAIT, ACCUM, PRESENT.
- IDLE: on SampleReq, latch LeftIn, RightIn and BandMask, set channel=0, go to ISSUE.
- ISSUE (1 cycle):
  - BandStart = latched mask.
  - XOut = the current channel's sample, held stable through ACCUM.
  - Timer cleared. Go to WAIT.
- WAIT:
  - The first cycle is a guard: BandReady is ignored.
  - From the second cycle, leave WAIT when (BandReady & mask) == mask.
  - An all-zero mask passes on the second cycle.
  - Leaving WAIT clears the accumulator and goes to ACCUM.
- Timeout: if the timer reaches TIMEOUT in WAIT, set TimeoutErr, force OutData=0 and go directly to PRESENT (skip ACCUM).
- ACCUM (exactly NUM_BANDS cycles):
  - Cycle i adds sign-extended BandResult[i] when mask[i]=1, else 0.
  - Then go to PRESENT.
- Saturation: the ACC_W result is clamped to 0x7FFF / 0x8000. OutData is registered on entry to PRESENT.
- PRESENT:
  - OutValid=1, OutData and OutChannel stable until OutReady.
  - On the handshake cycle: if channel=0, set channel=1 and go to ISSUE; else go to IDLE.
  - OutValid drops the cycle after the handshake.
- Latency (bands already ready): SampleReq sampled at edge 0 gives ISSUE in cycle 1, WAIT in cycles 2-3 and ACCUM in cycles 4-13. Left OutValid first asserts in cycle NUM_BANDS+4 (14).
- Overrun: SampleReq in any state other than IDLE is dropped and sets OverrunErr. This includes the right-channel handshake cycle.
- ClrErr clears both sticky errors. If a new error occurs in the same cycle, the set wins.
- Reset asserted mid-frame aborts immediately with no partial output. BandStart and OutValid go low asynchronously.

Decomposition:
- Package eq_sched_pkg:
  - state enum.
  - DATA_W/ACC_W defaults.
  - SAT_MAX=0x7FFF, SAT_MIN=0x8000 constants.
  - channel encoding (LEFT=0, RIGHT=1).
- Sub-module eq_sat_accum: clear/add-enable signed accumulator plus saturating truncation to DATA_W. Instantiated once. Top holds the FSM, timer, latches and handshake.

Test Plan:
1. Mask=0x3FF, every BandResult=0x0100, ready held high, OutReady=1 → left OutValid first asserts in cycle 14 with OutData=0x0A00, OutChannel=0; right follows with 0x0A00, OutChannel=1; BandStart=0x3FF pulses twice.
2. Mask=0x3FF, all results 0x7000 → OutData=0x7FFF. All results 0x9000 → OutData=0x8000.
3. Mask=0x005, results: band0=0x0010, band2=0x0020, others 0x1234 → OutData=0x0030.
4. Band 3 ready never asserts, mask=0x3FF, TIMEOUT=8 → TimeoutErr=1, OutData=0x0000 for left, then the right channel is reissued. ClrErr clears the flag.
5. SampleReq pulsed during ACCUM → OverrunErr=1, frame completes unchanged. OutReady held low 5 cycles → OutValid and OutData stable throughout.
6. Reset_ driven low during WAIT → all outputs 0 immediately. After release, a SampleReq completes a normal frame.
